// File: rtl/uart_tx_unpacker_pkg.sv
// uart_tx_unpacker shared definitions: widths, sel codes and sel decode.
// Writer and reader both use this so the word format has one definition.
package uart_tx_unpacker_pkg;

  localparam int ASYNC_FIFO_WIDTH = 51;
  localparam int VALUE_WIDTH      = 48;
  localparam int UART_DATA_WIDTH  = 8;
  localparam int CNT_WIDTH        = 16;

  localparam logic [2:0] SEL_PARL      = 3'd0;
  localparam logic [2:0] SEL_LONG_CONT = 3'd6;
  localparam logic [2:0] SEL_LONG_LAST = 3'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2
  } state_t;

  function automatic logic [2:0] sel_count(input logic [2:0] sel);
    logic [2:0] n;
    n = sel;
    unique case (1'b1)
      (sel == SEL_PARL):      n = 3'd1;
      (sel == SEL_LONG_LAST): n = 3'd6;
      default:                n = sel;
    endcase
    return n;
  endfunction

  function automatic logic sel_ends(input logic [2:0] sel);
    return sel != SEL_LONG_CONT;
  endfunction

endpackage

// File: rtl/uart_tx_unpacker.sv
// uart_tx_unpacker: pops 51-bit FIFO words and streams their valid
// payload bytes LSB-first over a valid/ready byte handshake.
module uart_tx_unpacker
  import uart_tx_unpacker_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        uart_en,
  input  logic                        fifo_empty,
  output logic                        fifo_rd_en,
  input  logic [ASYNC_FIFO_WIDTH-1:0] fifo_rd_data,
  output logic [UART_DATA_WIDTH-1:0]  tx_data,
  output logic                        tx_valid,
  input  logic                        tx_ready,
  output logic                        msg_end,
  output logic                        busy,
  output logic [CNT_WIDTH-1:0]        tx_byte_cnt
);

  state_t                 state;
  state_t                 state_nxt;
  logic [VALUE_WIDTH-1:0] shift;
  logic [2:0]             n;
  logic                   last;
  logic                   hs;
  logic [2:0]             sel;

  assign sel = fifo_rd_data[ASYNC_FIFO_WIDTH-1:VALUE_WIDTH];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state, pop strobe and byte-valid decode.
  always_comb begin
    state_nxt  = state;
    fifo_rd_en = 1'b0;
    tx_valid   = 1'b0;
    unique case (state)
      IDLE: begin
        if (rst_n && uart_en && !fifo_empty) begin
          fifo_rd_en = 1'b1;
          state_nxt  = FETCH;
        end
      end
      FETCH: state_nxt = SEND;
      SEND: begin
        tx_valid = 1'b1;
        if (tx_ready && n == 3'd1) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign hs      = tx_valid && tx_ready;
  assign tx_data = tx_valid ? shift[UART_DATA_WIDTH-1:0] : '0;
  assign busy    = state != IDLE;

  // Word capture, byte shifting, message-end pulse and sent counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift       <= '0;
      n           <= 3'd0;
      last        <= 1'b0;
      msg_end     <= 1'b0;
      tx_byte_cnt <= '0;
    end else begin
      msg_end <= hs && n == 3'd1 && last;
      if (state == FETCH) begin
        shift <= fifo_rd_data[VALUE_WIDTH-1:0];
        n     <= sel_count(sel);
        last  <= sel_ends(sel);
      end else if (hs) begin
        shift       <= shift >> UART_DATA_WIDTH;
        n           <= n - 3'd1;
        tx_byte_cnt <= tx_byte_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule
